// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: multi-digit hexadecimal 7-segment display controller.
//
// The value latch captures val on any edge with load high. HEX is fully
// registered and is recomputed every clock edge from the latched value, the
// live lz_blank and blink_mask inputs, and the blink phase. Segments are
// active-low and ordered gfedcba. Digit i occupies HEX[7i+6:7i].
//
// Optional feature macro: HEXDISP_BLINK_EN
//   defined   - a blink counter and phase register are built. While the
//               phase is high, every digit with blink_mask[i]=1 is dark.
//   undefined - no blink state is built. The phase is a constant 0, so
//               blink_mask has no effect on the display.
module hex_display_ctrl #(
    parameter int NDIGITS   = 8,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [4*NDIGITS-1:0]   val,
    input  logic                   lz_blank,
    input  logic [NDIGITS-1:0]     blink_mask,
    output logic [7*NDIGITS-1:0]   HEX
);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low gfedcba pattern for one hexadecimal nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            4'hF:    seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    logic [4*NDIGITS-1:0] r_val_q;
    logic [7*NDIGITS-1:0] r_hex;
    logic [7*NDIGITS-1:0] w_hex_next;
    // w_zero_run[i] = 1 when nibbles NDIGITS-1 down to i are all zero.
    // The extra top bit seeds the chain so the loop needs no special case.
    logic [NDIGITS:0]     w_zero_run;
    logic                 w_phase;

    // Value latch: capture val whenever load is high, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_val_q <= '0;
        end else if (load) begin
            r_val_q <= val;
        end else begin
            r_val_q <= r_val_q;
        end
    end

`ifdef HEXDISP_BLINK_EN
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    logic [CW-1:0] r_blink_cnt;
    logic          r_phase;

    // Blink timebase. A load restarts a full visible half-period, and it
    // takes priority over a wrap that falls on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (load) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (r_blink_cnt == CNT_LAST) begin
            r_blink_cnt <= '0;
            r_phase     <= ~r_phase;
        end else begin
            r_blink_cnt <= r_blink_cnt + {{(CW-1){1'b0}}, 1'b1};
            r_phase     <= r_phase;
        end
    end

    assign w_phase = r_phase;
`else
    assign w_phase = 1'b0;
`endif

    // Leading-zero detection, built from the most significant nibble downward.
    always_comb begin
        w_zero_run          = '0;
        w_zero_run[NDIGITS] = 1'b1;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            w_zero_run[i] = w_zero_run[i+1] & (r_val_q[4*i +: 4] == 4'h0);
        end
    end

    // Next display image. Leading-zero blanking and blink blanking combine
    // with OR. Digit 0 is never blanked for leading zeros.
    always_comb begin
        w_hex_next = '1;
        for (int i = 0; i < NDIGITS; i++) begin
            if ((lz_blank && (i != 0) && w_zero_run[i]) ||
                (w_phase && blink_mask[i])) begin
                w_hex_next[7*i +: 7] = SEG_BLANK;
            end else begin
                w_hex_next[7*i +: 7] = hex_to_seg(r_val_q[4*i +: 4]);
            end
        end
    end

    // Output register. Reset leaves every digit dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hex <= '1;
        end else begin
            r_hex <= w_hex_next;
        end
    end

    assign HEX = r_hex;

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Parametrised multi-digit hexadecimal 7-segment display controller for the DE-series board seven-segment banks.
- Generalises the single-digit decoder to NDIGITS digits with a registered value latch, leading-zero blanking and per-digit blinking.
- Sits between the datapath (value source) and the top-level HEX pin outputs. Segment encoding is active-low (bit 0 = segment a … bit 6 = segment g).

Parameters:
NDIGITS, 8, number of hex digits driven (1..8)
BLINK_DIV, 25000000, clock cycles per blink half-period (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
load  input  1  capture val on rising clk edge when high
val  input  4*NDIGITS  value to display; nibble i drives digit i (digit 0 = least significant)
lz_blank  input  1  1 = blank leading zero digits
blink_mask  input  NDIGITS  1 = digit i blinks
HEX  output  7*NDIGITS  active-low segments; bits [7i+6:7i] = digit i

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): val_q=0, blink counter=0, blink phase=0, HEX = all ones (every digit dark).
- Latch: on each edge with load=1, val_q <= val. Otherwise val_q holds. lz_blank and blink_mask are not latched; they are sampled live.
- Output register: HEX is fully registered and recomputed every edge from val_q, lz_blank, blink_mask and blink phase.
  - Latency from load=1 to HEX showing the new value: 2 edges. Edge 1 captures val_q; edge 2 updates HEX.
  - After reset release, the first edge shows val_q=0, subject to blanking.
- Decode per nibble (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Blank pattern is 1111111.
- Leading-zero blanking (lz_blank=1):
  - Digit i (i>=1) is blanked iff nibbles NDIGITS-1 down to i of val_q are all zero.
  - Digit 0 is never blanked, so val_q=0 shows a single "0".
  - lz_blank=0: all digits are decoded.
- Blink counter:
  - Counts 0..BLINK_DIV-1 and wraps to 0. On wrap, blink phase toggles.
  - While phase=1, every digit with blink_mask[i]=1 is forced blank. Blink blanking ORs with leading-zero blanking.
  - Any edge with load=1 resets the counter to 0 and phase to 0, so a newly loaded value is visible for a full half-period.
  - Width = $clog2(BLINK_DIV); no overflow beyond BLINK_DIV-1.
- Simultaneous events:
  - load=1 during phase=1 forces phase=0 on the same edge. The load takes priority over the counter wrap.
  - Reset mid-operation clears all state immediately (asynchronous). Operation resumes on the first edge after deassertion.
- Changing blink_mask or lz_blank affects HEX on the next edge (1-cycle latency).
- No other state. No handshake back-pressure: load is accepted every cycle, including back-to-back.

Optional Feature:
- Macro: HEXDISP_BLINK_EN.
- Defined: blink counter and phase are present, and blink_mask behaves as above.
- Undefined:
  - No counter or phase registers are synthesised; phase is treated as constant 0.
  - blink_mask is accepted but ignored.
  - load affects only val_q.
  - All other behaviour and latencies are unchanged.

Test Plan:
All scenarios use NDIGITS=4 and BLINK_DIV=4, with HEX digits listed from digit 3 to digit 0.
- Reset, then release with load=0 and lz_blank=0 -> HEX=all 1111111 during reset. One edge after release, every digit = 1000000.
- load=1 for one cycle with val=16'h12AF, lz_blank=0 -> 2 edges later digits 3..0 = 1111001, 0100100, 0001000, 0001110; the value holds after load drops.
- val_q=16'h0040 with lz_blank=1 -> digits 3,2 = 1111111, digit 1 = 0011001, digit 0 = 1000000. val_q=16'h0000 with lz_blank=1 -> only digit 0 lit = 1000000.
- HEXDISP_BLINK_EN defined, val_q=16'h1234, blink_mask=4'b0001 -> digit 0 alternates between 0011001 and 1111111 every 4 cycles; digits 3..1 remain steady.
- Blink running in phase=1 with load=1 and val=16'h5555 -> phase is cleared on that edge; next edge shows all four digits = 0010010, held for 4 cycles.
- Blink running, then rst_n pulsed low mid-cycle -> HEX goes all 1111111 immediately, without a clock edge; val_q=0 after release.
